// File: rtl/tsu_q_fetch.sv
// -----------------------------------------------------------------------------
// tsu_q_fetch
// Bus initiator that pulls one 128-bit timestamp entry out of the RX or TX
// TSU queue of the PTP register block. It runs the queue-read handshake in
// hardware, then presents the entry on a valid/ready stream.
//
// The handshake is: read status, clear and then set the ctrl read bit, wait for
// the ctrl-bit synchroniser, poll the ok flag, and read four data words.
//
// Optional build macro: TSU_Q_FETCH_DRAIN_EN
//   When defined, the block returns to the status read after each delivered
//   entry, so it keeps fetching until the queue reports empty.
//   When undefined, each start_in fetches exactly one entry.
//
// Parameters
//   SETTLE_CYC    idle cycles between the ctrl rising-edge write and the
//                 first ok poll (must be >= 6)
//   POLL_MAX      ctrl reads allowed while waiting for ok
//
// Ports
//   clk           bus clock, also the TSU queue read clock
//   rst           asynchronous active-high reset
//   start_in      one-cycle fetch request, sampled only while idle
//   sel_tx_in     queue select sampled with start_in (0 = RX @0x40, 1 = TX @0x60)
//   wr_out        bus write strobe
//   rd_out        bus read strobe
//   addr_out      bus byte address
//   data_out      bus write data
//   data_in       bus read data, valid the cycle after rd_out
//   ts_valid_out  ts_data_out holds an entry
//   ts_ready_in   consumer accepts the entry
//   ts_data_out   entry {word@+0x10, word@+0x14, word@+0x18, word@+0x1C}
//   busy_out      FSM not idle
//   empty_out     sticky: the fetch found an empty queue
//   timeout_out   sticky: the fetch ran out of ok polls
// -----------------------------------------------------------------------------
module tsu_q_fetch #(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned POLL_MAX   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_in,
    input  logic         sel_tx_in,
    output logic         wr_out,
    output logic         rd_out,
    output logic [7:0]   addr_out,
    output logic [31:0]  data_out,
    input  logic [31:0]  data_in,
    output logic         ts_valid_out,
    input  logic         ts_ready_in,
    output logic [127:0] ts_data_out,
    output logic         busy_out,
    output logic         empty_out,
    output logic         timeout_out
);

    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned PW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_STAT_RD, S_STAT_CAP, S_CLR, S_SET, S_SETTLE,
        S_POLL_RD, S_POLL_CAP, S_DATA_RD, S_DATA_CAP, S_OUT, S_ABORT
    } state_t;

    state_t         state_r, state_s;
    logic [7:0]     base_r, base_s;
    logic [SW-1:0]  settle_r, settle_s;
    logic [PW-1:0]  poll_r, poll_s;
    logic [1:0]     word_r, word_s;
    logic           delivered_r, delivered_s;
    logic [127:0]   ts_data_r, ts_data_s;
    logic           empty_r, empty_s;
    logic           timeout_r, timeout_s;
    logic           wr_r, wr_s;
    logic           rd_r, rd_s;
    logic [7:0]     addr_r, addr_s;
    logic [31:0]    wdata_r, wdata_s;
    logic           valid_r, valid_s;
    logic           busy_r, busy_s;

    // Next-state, datapath and next-cycle bus strobes. The bus outputs are
    // decoded from the next state so they can be driven straight from flops.
    always_comb begin
        state_s     = state_r;
        base_s      = base_r;
        settle_s    = settle_r;
        poll_s      = poll_r;
        word_s      = word_r;
        delivered_s = delivered_r;
        ts_data_s   = ts_data_r;
        empty_s     = empty_r;
        timeout_s   = timeout_r;

        case (state_r)
            S_IDLE: begin
                if (start_in) begin
                    base_s      = sel_tx_in ? 8'h60 : 8'h40;
                    empty_s     = 1'b0;
                    timeout_s   = 1'b0;
                    delivered_s = 1'b0;
                    state_s     = S_STAT_RD;
                end else begin
                    state_s     = S_IDLE;
                end
            end
            S_STAT_RD:  state_s = S_STAT_CAP;
            S_STAT_CAP: begin
                if (data_in[7:0] == 8'h00) begin
                    // An empty status after a delivered entry is the normal
                    // end of a drain, not an empty-queue event.
                    empty_s = ~delivered_r;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_CLR;
                end
            end
            S_CLR: state_s = S_SET;
            S_SET: begin
                settle_s = SW'(SETTLE_CYC - 1);
                state_s  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_r == {SW{1'b0}}) begin
                    poll_s  = {PW{1'b0}};
                    state_s = S_POLL_RD;
                end else begin
                    settle_s = settle_r - {{(SW-1){1'b0}}, 1'b1};
                end
            end
            S_POLL_RD: begin
                poll_s  = poll_r + {{(PW-1){1'b0}}, 1'b1};
                state_s = S_POLL_CAP;
            end
            S_POLL_CAP: begin
                if (data_in[0]) begin
                    word_s  = 2'd0;
                    state_s = S_DATA_RD;
                end else if (poll_r == PW'(POLL_MAX)) begin
                    timeout_s = 1'b1;
                    state_s   = S_ABORT;
                end else begin
                    state_s   = S_POLL_RD;
                end
            end
            S_DATA_RD: state_s = S_DATA_CAP;
            S_DATA_CAP: begin
                // First word read ends up in the most significant slot.
                ts_data_s = {ts_data_r[95:0], data_in};
                if (word_r == 2'd3) begin
                    state_s = S_OUT;
                end else begin
                    word_s  = word_r + 2'd1;
                    state_s = S_DATA_RD;
                end
            end
            S_OUT: begin
                if (ts_ready_in) begin
                    delivered_s = 1'b1;
`ifdef TSU_Q_FETCH_DRAIN_EN
                    state_s     = S_STAT_RD;
`else
                    state_s     = S_IDLE;
`endif
                end else begin
                    state_s     = S_OUT;
                end
            end
            S_ABORT: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase

        wr_s    = 1'b0;
        rd_s    = 1'b0;
        addr_s  = 8'h00;
        wdata_s = 32'h0000_0000;
        case (state_s)
            S_STAT_RD: begin
                rd_s   = 1'b1;
                addr_s = base_s + 8'h04;
            end
            S_CLR, S_ABORT: begin
                wr_s   = 1'b1;
                addr_s = base_s;
            end
            S_SET: begin
                wr_s    = 1'b1;
                addr_s  = base_s;
                wdata_s = 32'h0000_0001;
            end
            S_POLL_RD: begin
                rd_s   = 1'b1;
                addr_s = base_s;
            end
            S_DATA_RD: begin
                rd_s   = 1'b1;
                addr_s = base_s + 8'h10 + {4'h0, word_s, 2'b00};
            end
            default: begin
                rd_s   = 1'b0;
            end
        endcase
        valid_s = (state_s == S_OUT);
        busy_s  = (state_s != S_IDLE);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            base_r      <= 8'h40;
            settle_r    <= {SW{1'b0}};
            poll_r      <= {PW{1'b0}};
            word_r      <= 2'd0;
            delivered_r <= 1'b0;
            ts_data_r   <= 128'h0;
            empty_r     <= 1'b0;
            timeout_r   <= 1'b0;
            wr_r        <= 1'b0;
            rd_r        <= 1'b0;
            addr_r      <= 8'h00;
            wdata_r     <= 32'h0000_0000;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            base_r      <= base_s;
            settle_r    <= settle_s;
            poll_r      <= poll_s;
            word_r      <= word_s;
            delivered_r <= delivered_s;
            ts_data_r   <= ts_data_s;
            empty_r     <= empty_s;
            timeout_r   <= timeout_s;
            wr_r        <= wr_s;
            rd_r        <= rd_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            valid_r     <= valid_s;
            busy_r      <= busy_s;
        end
    end

    assign wr_out       = wr_r;
    assign rd_out       = rd_r;
    assign addr_out     = addr_r;
    assign data_out     = wdata_r;
    assign ts_valid_out = valid_r;
    assign ts_data_out  = ts_data_r;
    assign busy_out     = busy_r;
    assign empty_out    = empty_r;
    assign timeout_out  = timeout_r;

endmodule

// File: doc/tsu_q_fetch.md
Name: tsu_q_fetch

Overview:
- Bus initiator that drives the PTP register block's generic bus (wr/rd/addr/data) to pull timestamps out of the RX or TX TSU queue.
- Performs the queue-read handshake in hardware: read status, pulse the ctrl read bit, poll the ok flag, read four data words.
- Delivers each 128-bit entry on a valid/ready stream.
- Sits between an on-chip consumer (PTP stack offload or DMA) and the register block, on the register block's bus clock.

Parameters:
- SETTLE_CYC, 8, idle cycles after the ctrl rising-edge write before the first ok poll; must be >= 6 to cover the ctrl-bit synchroniser.
- POLL_MAX, 16, maximum number of ctrl reads while waiting for ok before declaring timeout.

Ports:
- clk  in  1  bus clock; also the TSU queue read clock.
- rst  in  1  asynchronous, active-high reset.
- start_in  in  1  one-cycle fetch request; sampled only in IDLE.
- sel_tx_in  in  1  queue select, sampled with start_in: 0 = RX (base 0x40), 1 = TX (base 0x60).
- wr_out  out  1  bus write strobe.
- rd_out  out  1  bus read strobe.
- addr_out  out  8  bus byte address.
- data_out  out  32  bus write data.
- data_in  in  32  bus read data, valid the cycle after rd_out.
- ts_valid_out  out  1  ts_data_out holds an entry.
- ts_ready_in  in  1  consumer accepts the entry.
- ts_data_out  out  128  entry: {word@+0x10, word@+0x14, word@+0x18, word@+0x1C}.
- busy_out  out  1  high whenever the FSM is not in IDLE.
- empty_out  out  1  sticky: last fetch found status == 0; cleared on start.
- timeout_out  out  1  sticky: last fetch hit POLL_MAX; cleared on start.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; base register = 0x40. Asserting rst mid-operation aborts immediately with no cleanup bus cycles.
- Bus rules:
  - rd_out and wr_out are single-cycle pulses and are never asserted together.
  - addr_out and data_out are valid in the strobe cycle only; they are 0 otherwise.
  - Read data is captured exactly one cycle after rd_out.
- FSM states and transitions:
  - IDLE: on start_in, latch base from sel_tx_in, clear empty_out/timeout_out, go to STAT.
  - STAT: rd base+0x04. Next cycle capture data_in[7:0] as the entry count. If 0: set empty_out, go to IDLE. Else go to CLR.
  - CLR: wr base+0x00 with data 0x0 (rst bit 0, rd bit 0). Go to SET.
  - SET: wr base+0x00 with data 0x1. This produces the rising edge the register block needs. Load settle counter; go to SETTLE.
  - SETTLE: wait SETTLE_CYC cycles; go to POLL.
  - POLL: rd base+0x00; capture bit0 the next cycle.
    - bit0 = 1: go to DATA.
    - Else, if poll count reaches POLL_MAX: set timeout_out, go to ABORT.
    - Else issue the next poll in the cycle after capture.
  - DATA: read base+0x10, 0x14, 0x18, 0x1C in order, each read followed by its capture cycle (8 cycles total). Shift words into ts_data_out MSW first. Go to OUT.
  - OUT: ts_valid_out = 1, held stable until ts_ready_in is seen high. ts_valid_out drops the cycle after the handshake; go to IDLE (see Optional Feature).
  - ABORT: wr base+0x00 data 0x0; go to IDLE.
- Single-entry latency, start to ts_valid_out with one poll at SETTLE_CYC = 8: 1 + 2 + 1 + 1 + 8 + 2 + 8 = 23 cycles.
- Each failed poll adds 2 cycles.
- ts_ready_in high before valid is ignored; no combinational ready-to-valid path.
- start_in while busy_out = 1 is ignored and not queued.

Optional Feature:
- Macro: TSU_Q_FETCH_DRAIN_EN.
- Defined: after the OUT handshake, return to STAT instead of IDLE. The block keeps fetching entries until status reads 0.
  - Terminating on an empty status read leaves empty_out = 0 once at least one entry has been delivered.
  - empty_out = 1 only when the very first status read is 0.
- Not defined: exactly one entry per start_in.

Test Plan:
- Reset mid-POLL (rst high 1 cycle) -> next cycle: all outputs 0, busy_out = 0; a subsequent start_in runs a full sequence.
- start_in, sel_tx_in = 0; status 0x03; ok on first poll; data 0x11111111 / 0x22222222 / 0x33333333 / 0x44444444 -> bus trace:
  - rd 0x44, wr 0x40 = 0, wr 0x40 = 1, 8 idle cycles, rd 0x40, rd 0x50..0x5C;
  - ts_valid_out at cycle 23 with ts_data_out = 0x11111111_22222222_33333333_44444444.
- sel_tx_in = 1, status 0x00 -> single rd 0x64, no write, empty_out = 1, busy_out low 3 cycles after start.
- ok bit never set, POLL_MAX = 16 -> exactly 16 rd 0x60, then wr 0x60 = 0, timeout_out = 1, no ts_valid_out.
- ts_ready_in held low 10 cycles with valid asserted -> ts_valid_out and ts_data_out stable throughout; start_in pulsed during the wait is ignored.
- With TSU_Q_FETCH_DRAIN_EN, status sequence 2, 1, 0 -> two entries delivered, three status reads, empty_out = 0, then IDLE.
